// File: rtl/checker_sequencer.sv
// Walks a directed vector table, opens a checker_run window per vector, and tallies
// the checker's pass/fail verdicts with a local timeout guard for silent checkers.
module checker_sequencer #(
  parameter int NUM_TESTS  = 16,
  parameter int IDX_W      = 4,
  parameter int TIMEOUT    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  output logic [IDX_W-1:0]  vec_idx,
  input  logic [4:0]        vec_rd,
  input  logic [31:0]       vec_expected,
  output logic              checker_run,
  output logic [4:0]        rd,
  output logic [31:0]       expected,
  input  logic              chk_pass,
  input  logic              chk_fail,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    pass_count,
  output logic [IDX_W:0]    fail_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic              any_fail,
  output logic              proto_err
);

  localparam int CNT_W  = IDX_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(NUM_TESTS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TESTS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        expected_q, expected_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   pass_count_q, pass_count_d;
  logic [CNT_W-1:0]   fail_count_q, fail_count_d;
  logic [IDX_W-1:0]   first_fail_idx_q, first_fail_idx_d;
  logic               any_fail_q, any_fail_d;
  logic               proto_err_q, proto_err_d;
  logic               checker_run_q, checker_run_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_hit;
  logic               pass_hit;

  // Counts hold at NUM_TESTS rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_d          = state_q;
    vec_idx_d        = vec_idx_q;
    rd_d             = rd_q;
    expected_d       = expected_q;
    wait_cnt_d       = wait_cnt_q;
    gap_cnt_d        = gap_cnt_q;
    pass_count_d     = pass_count_q;
    fail_count_d     = fail_count_q;
    first_fail_idx_d = first_fail_idx_q;
    any_fail_d       = any_fail_q;
    proto_err_d      = proto_err_q;
    fail_hit         = 1'b0;
    pass_hit         = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pass_count_d     = '0;
          fail_count_d     = '0;
          first_fail_idx_d = '0;
          any_fail_d       = 1'b0;
          proto_err_d      = 1'b0;
          vec_idx_d        = '0;
          state_d          = LOAD;
        end
      end
      LOAD: begin
        rd_d       = vec_rd;
        expected_d = vec_expected;
        wait_cnt_d = '0;
        state_d    = RUN;
      end
      RUN: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (chk_pass && chk_fail) begin
          proto_err_d = 1'b1;
          fail_hit    = 1'b1;
        end else if (chk_fail) begin
          fail_hit = 1'b1;
        end else if (chk_pass) begin
          pass_hit = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fail_hit = 1'b1;
        end

        if (pass_hit) begin
          pass_count_d = sat_inc(pass_count_q);
        end
        if (fail_hit) begin
          fail_count_d = sat_inc(fail_count_q);
          if (!any_fail_q) begin
            any_fail_d       = 1'b1;
            first_fail_idx_d = vec_idx_q;
          end
        end
        if (pass_hit || fail_hit) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (vec_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            vec_idx_d = vec_idx_q + IDX_W'(1);
            state_d   = LOAD;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // checker_run lags the RUN state by one cycle; busy/done track the next state.
    checker_run_d = (state_q == RUN);
    busy_d        = (state_d == LOAD) || (state_d == RUN) || (state_d == GAP);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= IDLE;
      vec_idx_q        <= '0;
      rd_q             <= '0;
      expected_q       <= '0;
      wait_cnt_q       <= '0;
      gap_cnt_q        <= '0;
      pass_count_q     <= '0;
      fail_count_q     <= '0;
      first_fail_idx_q <= '0;
      any_fail_q       <= 1'b0;
      proto_err_q      <= 1'b0;
      checker_run_q    <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_idx_q        <= vec_idx_d;
      rd_q             <= rd_d;
      expected_q       <= expected_d;
      wait_cnt_q       <= wait_cnt_d;
      gap_cnt_q        <= gap_cnt_d;
      pass_count_q     <= pass_count_d;
      fail_count_q     <= fail_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      any_fail_q       <= any_fail_d;
      proto_err_q      <= proto_err_d;
      checker_run_q    <= checker_run_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign vec_idx        = vec_idx_q;
  assign rd             = rd_q;
  assign expected       = expected_q;
  assign checker_run    = checker_run_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_count     = pass_count_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_idx_q;
  assign any_fail       = any_fail_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_checker_sequencer.sv
// Directed bench for checker_sequencer: four-entry vector table with a scripted checker.
module tb_checker_sequencer;
  localparam int NT = 4;
  localparam int IW = 2;
  localparam int TO = 8;
  localparam int GC = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          start = 1'b0;
  logic          chk_pass = 1'b0;
  logic          chk_fail = 1'b0;
  logic [IW-1:0] vec_idx;
  logic [4:0]    vec_rd;
  logic [31:0]   vec_expected;
  logic          checker_run;
  logic [4:0]    rd;
  logic [31:0]   expected;
  logic          busy;
  logic          done;
  logic [IW:0]   pass_count;
  logic [IW:0]   fail_count;
  logic [IW-1:0] first_fail_idx;
  logic          any_fail;
  logic          proto_err;

  logic [4:0]  tbl_rd  [NT] = '{5'd5, 5'd1, 5'd31, 5'd10};
  logic [31:0] tbl_exp [NT] = '{32'hDEADBEEF, 32'h0000_0011, 32'hFFFF_FFFF, 32'h1234_5678};

  // Checker behaviour per vector: 0 pass, 1 fail, 2 silent, 3 pass+fail together.
  int   mode    [NT];
  int   run_len [NT];
  int   windows;
  logic stable_ok;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 Clk = ~Clk;

  assign vec_rd       = tbl_rd[vec_idx];
  assign vec_expected = tbl_exp[vec_idx];

  checker_sequencer #(
    .NUM_TESTS (NT),
    .IDX_W     (IW),
    .TIMEOUT   (TO),
    .GAP_CYCLES(GC)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .start         (start),
    .vec_idx       (vec_idx),
    .vec_rd        (vec_rd),
    .vec_expected  (vec_expected),
    .checker_run   (checker_run),
    .rd            (rd),
    .expected      (expected),
    .chk_pass      (chk_pass),
    .chk_fail      (chk_fail),
    .busy          (busy),
    .done          (done),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .first_fail_idx(first_fail_idx),
    .any_fail      (any_fail),
    .proto_err     (proto_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
    mode[0] = m0;
    mode[1] = m1;
    mode[2] = m2;
    mode[3] = m3;
  endtask

  task automatic start_pulse();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(input bit mid_start);
    int hi;
    logic prev;
    hi        = 0;
    prev      = 1'b0;
    windows   = 0;
    stable_ok = 1'b1;
    for (int i = 0; i < NT; i++) run_len[i] = 0;
    for (int cyc = 0; cyc < 400 && done !== 1'b1; cyc++) begin
      @(negedge Clk);
      chk_pass = 1'b0;
      chk_fail = 1'b0;
      start    = 1'b0;
      if (checker_run === 1'b1) begin
        if (!prev) windows++;
        hi++;
        run_len[vec_idx]++;
        if (rd !== tbl_rd[vec_idx] || expected !== tbl_exp[vec_idx]) stable_ok = 1'b0;
        if (hi == 3) begin
          case (mode[vec_idx])
            0: chk_pass = 1'b1;
            1: chk_fail = 1'b1;
            3: begin
              chk_pass = 1'b1;
              chk_fail = 1'b1;
            end
            default: ;
          endcase
        end
        if (mid_start && vec_idx == 2'd1 && hi == 2) start = 1'b1;
      end else begin
        hi = 0;
      end
      prev = checker_run;
    end
    chk_pass = 1'b0;
    chk_fail = 1'b0;
    start    = 1'b0;
    check("reached_done", 64'(done), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({vec_idx, checker_run, busy, done, pass_count, fail_count,
                    first_fail_idx, any_fail, proto_err}), 64'd0);
    check({tag, "_rd_exp"}, {27'd0, rd, expected}, 64'd0);
  endtask

  initial begin
    bit found;

    // Reset state
    #2 Reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Test 1: all pass, plus start-to-checker_run latency
    set_modes(0, 0, 0, 0);
    start_pulse();
    check("t1_busy_in_load", 64'(busy), 64'd1);
    check("t1_run_low_load", 64'(checker_run), 64'd0);
    @(negedge Clk);
    check("t1_run_low_n1", 64'(checker_run), 64'd0);
    @(negedge Clk);
    check("t1_run_high_n2", 64'(checker_run), 64'd1);
    run_to_done(1'b0);
    check("t1_pass", 64'(pass_count), 64'd4);
    check("t1_fail", 64'(fail_count), 64'd0);
    check("t1_any_fail", 64'(any_fail), 64'd0);
    check("t1_proto", 64'(proto_err), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_vec_idx", 64'(vec_idx), 64'd3);
    check("t1_windows", 64'(windows), 64'd4);

    // Test 2: fails on vectors 1 and 3
    set_modes(0, 1, 0, 1);
    start_pulse();
    run_to_done(1'b0);
    check("t2_pass", 64'(pass_count), 64'd2);
    check("t2_fail", 64'(fail_count), 64'd2);
    check("t2_first_fail", 64'(first_fail_idx), 64'd1);
    check("t2_any_fail", 64'(any_fail), 64'd1);
    check("t2_stable", 64'(stable_ok), 64'd1);

    // Test 6: start in DONE clears, start during RUN ignored
    set_modes(0, 0, 0, 0);
    start_pulse();
    check("t6_pass_clr", 64'(pass_count), 64'd0);
    check("t6_fail_clr", 64'(fail_count), 64'd0);
    check("t6_any_clr", 64'(any_fail), 64'd0);
    check("t6_first_clr", 64'(first_fail_idx), 64'd0);
    check("t6_done_clr", 64'(done), 64'd0);
    check("t6_vec_idx", 64'(vec_idx), 64'd0);
    @(negedge Clk);
    check("t6_rd_x5", 64'(rd), 64'd5);
    check("t6_exp_deadbeef", 64'(expected), 64'hDEADBEEF);
    run_to_done(1'b1);
    check("t6_windows", 64'(windows), 64'd4);
    check("t6_pass", 64'(pass_count), 64'd4);
    check("t6_stable", 64'(stable_ok), 64'd1);

    // Test 3: silent checker on vector 2
    set_modes(0, 0, 2, 0);
    start_pulse();
    run_to_done(1'b0);
    check("t3_run_len", 64'(run_len[2]), 64'd8);
    check("t3_fail", 64'(fail_count), 64'd1);
    check("t3_pass", 64'(pass_count), 64'd3);
    check("t3_first_fail", 64'(first_fail_idx), 64'd2);
    check("t3_any_fail", 64'(any_fail), 64'd1);

    // Test 4: pass and fail together on vector 0
    set_modes(3, 0, 0, 0);
    start_pulse();
    run_to_done(1'b0);
    check("t4_proto", 64'(proto_err), 64'd1);
    check("t4_fail", 64'(fail_count), 64'd1);
    check("t4_pass", 64'(pass_count), 64'd3);
    check("t4_first_fail", 64'(first_fail_idx), 64'd0);
    check("t4_any_fail", 64'(any_fail), 64'd1);

    // Test 5: reset during RUN of vector 2, then rerun
    set_modes(0, 0, 0, 0);
    start_pulse();
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge Clk);
      if (vec_idx == 2'd2 && checker_run === 1'b1) found = 1'b1;
    end
    check("t5_reached_vec2", 64'(found), 64'd1);
    Reset_n = 1'b0;
    #1 check_all_zero("t5_reset");
    repeat (2) @(negedge Clk);
    check("t5_idle_stays", 64'(busy), 64'd0);
    Reset_n = 1'b1;
    start_pulse();
    check("t5_restart_idx", 64'(vec_idx), 64'd0);
    check("t5_restart_busy", 64'(busy), 64'd1);
    run_to_done(1'b0);
    check("t5_pass", 64'(pass_count), 64'd4);
    check("t5_windows", 64'(windows), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
